// File: rtl/game_pkg.sv
`default_nettype none
// game_pkg: playfield constants, colours and FSM state encoding shared by the drawers.
// Rev 1.0
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'd0;
  localparam logic [2:0] COL_GREEN = 3'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_DRAW = ST_DRAW,
    S_DONE = ST_DONE
  } state_t;

  // Counter width for a range of n values, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// raster_counter: hold / column / row nested counter walking a W x H block, HOLD cycles per cell.
// Rev 1.0
module raster_counter
  import game_pkg::*;
#(
  parameter int BEAM_W = 4,
  parameter int BEAM_H = 115,
  parameter int HOLD   = 2,
  localparam int XW    = game_pkg::cnt_w(BEAM_W),
  localparam int YW    = game_pkg::cnt_w(BEAM_H),
  localparam int HW    = game_pkg::cnt_w(HOLD)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] xo,
  output logic [YW-1:0] yo,
  output logic          last
);

  logic [HW-1:0] hold;
  logic          hold_end;
  logic          row_end;

  assign hold_end = (hold == HW'(HOLD - 1));
  assign row_end  = (xo == XW'(BEAM_W - 1));
  assign last     = hold_end && row_end && (yo == YW'(BEAM_H - 1));

  // Wraps to the origin after the final step so a free-running enable stays in range.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      hold <= '0;
      xo   <= '0;
      yo   <= '0;
    end else if (en) begin
      if (!hold_end) begin
        hold <= hold + HW'(1);
      end else begin
        hold <= '0;
        if (!row_end) begin
          xo <= xo + XW'(1);
        end else begin
          xo <= '0;
          yo <= last ? '0 : yo + YW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/beam_raster.sv
`default_nettype none
// beam_raster: rasters a clipped BEAM_W x BEAM_H filled rectangle into the VGA write port.
// Rev 1.0
module beam_raster #(
  parameter int BEAM_W   = 4,
  parameter int BEAM_H   = 115,
  parameter int HOLD     = 2,
  parameter int SCREEN_W = game_pkg::SCREEN_W,
  parameter int SCREEN_H = game_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       erase,
  input  logic [2:0] colour_in,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] c_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  import game_pkg::*;

  localparam int XW = cnt_w(BEAM_W);
  localparam int YW = cnt_w(BEAM_H);

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

  state_t        state;
  logic [7:0]    x_org;
  logic [6:0]    y_org;
  logic [2:0]    colour;
  logic          pix_last;

  logic [XW-1:0] xo;
  logic [YW-1:0] yo;
  logic          cnt_last;
  logic          cnt_en;
  logic          cnt_clr;

  logic          accept;
  logic          load_pix;
  logic [7:0]    ox_sel;
  logic [6:0]    oy_sel;
  logic [2:0]    col_sel;
  logic [8:0]    sum_x;
  logic [7:0]    sum_y;
  logic          on_screen;

  // The counter runs one step ahead of the output registers: it is advanced on the
  // accepting edge so that every edge can register the pixel for the following cycle.
  assign accept   = (state == S_IDLE) && start;
  assign cnt_en   = accept || (state == S_DRAW);
  assign cnt_clr  = !cnt_en;
  assign load_pix = accept || ((state == S_DRAW) && !pix_last);

  raster_counter #(
    .BEAM_W (BEAM_W),
    .BEAM_H (BEAM_H),
    .HOLD   (HOLD)
  ) u_counter (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .xo     (xo),
    .yo     (yo),
    .last   (cnt_last)
  );

  // In IDLE the counter sits at (0,0), so the first pixel comes straight from the inputs.
  assign ox_sel  = (state == S_IDLE) ? x0 : x_org;
  assign oy_sel  = (state == S_IDLE) ? y0 : y_org;
  assign col_sel = (state == S_IDLE) ? (erase ? COL_BLACK : colour_in) : colour;

  assign sum_x     = {1'b0, ox_sel} + 9'(xo);
  assign sum_y     = {1'b0, oy_sel} + 8'(yo);
  assign on_screen = (sum_x < X_LIM) && (sum_y < Y_LIM);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      x_org    <= '0;
      y_org    <= '0;
      colour   <= '0;
      pix_last <= 1'b0;
      x        <= '0;
      y        <= '0;
      c_out    <= '0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (load_pix) begin
        x        <= sum_x[7:0];
        y        <= sum_y[6:0];
        c_out    <= col_sel;
        plot     <= on_screen;
        pix_last <= cnt_last;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_DRAW;
            x_org  <= x0;
            y_org  <= y0;
            colour <= col_sel;
            busy   <= 1'b1;
          end
        end
        S_DRAW: begin
          if (pix_last) begin
            state <= S_DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
